onehot_splitter: RTL and testbench

Upstream feeder for the one-hot encoder path. Accepts a multi-bit request vector over a valid/ready handshake and replays it downstream as a sequence of one-hot words, lowest set bit first. Each word is a legal encoder input, so the downstream encoder (e.g. `ENCODER_f` with the same width) always sees exactly one bit set. Zero vectors are dropped and flagged.

---
 rtl/onehot_splitter.sv | 114 +++++++++++
 tb/tb_onehot_splitter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/onehot_splitter.sv
// ---------------------------------------------------------------------------
// onehot_splitter
//
// Takes a multi-bit request vector over a valid/ready handshake. It replays
// the vector downstream as a series of one-hot words, lowest set bit first.
// Every word it emits has exactly one bit set, so a one-hot encoder of the
// same width can use it directly. All-zero vectors are accepted, discarded,
// and reported with a one-cycle pulse.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous, active-low reset
//   in_valid    upstream offers in_vec
//   in_ready    block accepts in_vec this cycle
//   in_vec      request vector, any bit pattern
//   out_valid   out_onehot holds a valid word
//   out_ready   downstream consumes the current word
//   out_onehot  current word (lowest pending bit)
//   out_last    current word is the final one of its vector
//   pend_cnt    bits still pending, including the current word
//   zero_drop   pulse: an all-zero vector was accepted and dropped
// ---------------------------------------------------------------------------
module onehot_splitter #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_onehot,
  output logic             out_last,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             zero_drop
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             zero_drop_q, zero_drop_d;

  logic             emit;
  logic [WIDTH-1:0] lowest_bit;
  logic             single_bit;
  logic [CNT_W-1:0] pop_cnt;

  assign emit       = (state_q == EMIT);
  // Two's-complement trick: isolates the lowest set bit of pending.
  assign lowest_bit = pending_q & (~pending_q + ONE);
  // x & (x-1) clears the lowest set bit. A zero result on a non-zero x
  // means exactly one bit is set.
  assign single_bit = (pending_q != '0) && ((pending_q & (pending_q - ONE)) == '0);

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_cnt = pop_cnt + CNT_W'(pending_q[i]);
    end
  end

  // Outputs depend only on registered state. The one exception is in_ready,
  // which looks at out_ready so that a finishing vector can be replaced
  // without a bubble cycle.
  assign out_valid  = emit;
  assign out_onehot = emit ? lowest_bit : '0;
  assign out_last   = emit && single_bit;
  assign pend_cnt   = emit ? pop_cnt : '0;
  assign zero_drop  = zero_drop_q;
  assign in_ready   = !emit || (single_bit && out_ready);

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    zero_drop_d = 1'b0;

    // Retire the current word when downstream takes it.
    if (emit && out_ready) begin
      pending_d = pending_q & ~lowest_bit;
      if (single_bit) begin
        state_d = IDLE;
      end
    end

    // Accept a new vector. In EMIT this only happens on the last beat, and
    // that beat has already emptied pending above.
    if (in_valid && in_ready) begin
      if (in_vec != '0) begin
        pending_d = in_vec;
        state_d   = EMIT;
      end else begin
        zero_drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      zero_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      zero_drop_q <= zero_drop_d;
    end
  end

endmodule

// File: tb/tb_onehot_splitter.sv
// ---------------------------------------------------------------------------
// Testbench for onehot_splitter (WIDTH=8).
//
// The reference model treats each accepted vector as a queue of set-bit
// indices in ascending order. Each beat pops one index from the queue. The
// bench runs the directed scenarios first, then randomized traffic. All
// checks are made mid-cycle, after the inputs for that cycle are driven.
// ---------------------------------------------------------------------------
module tb_onehot_splitter;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_vec;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_onehot;
  logic          out_last;
  logic [CW-1:0] pend_cnt;
  logic          zero_drop;

  onehot_splitter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vec     (in_vec),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_last   (out_last),
    .pend_cnt   (pend_cnt),
    .zero_drop  (zero_drop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int           bit_q[$];   // pending bit indices, lowest first
  logic         zd_exp;     // zero_drop expected this cycle
  logic         exp_valid;
  logic         exp_rdy;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] encode(input logic [W-1:0] v);
    logic [2:0] r = '0;
    for (int i = 0; i < W; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  // Drive one cycle of inputs at the falling edge, then compare the DUT
  // against the model.
  task automatic drive(input logic iv, input logic [W-1:0] vec, input logic ordy);
    logic [W-1:0] hot;
    @(negedge clk);
    in_valid  = iv;
    in_vec    = vec;
    out_ready = ordy;
    #1;
    exp_valid = (bit_q.size() > 0);
    hot = '0;
    if (exp_valid) hot[bit_q[0]] = 1'b1;
    exp_rdy = (bit_q.size() == 0) || (bit_q.size() == 1 && ordy);
    check_eq("out_valid",  32'(out_valid),  32'(exp_valid));
    check_eq("out_onehot", 32'(out_onehot), 32'(hot));
    check_eq("out_last",   32'(out_last),   32'(bit_q.size() == 1));
    check_eq("pend_cnt",   32'(pend_cnt),   32'(bit_q.size()));
    check_eq("in_ready",   32'(in_ready),   32'(exp_rdy));
    check_eq("zero_drop",  32'(zero_drop),  32'(zd_exp));
  endtask

  // Advance through the rising edge and update the model.
  task automatic step();
    @(posedge clk);
    zd_exp = 1'b0;
    if (exp_valid && out_ready) void'(bit_q.pop_front());
    if (in_valid && exp_rdy) begin
      if (in_vec != '0) begin
        for (int i = 0; i < W; i++) if (in_vec[i]) bit_q.push_back(i);
        $display("accept vec=%02h beats=%0d", in_vec, bit_q.size());
      end else begin
        zd_exp = 1'b1;
        $display("accept vec=00 dropped");
      end
    end
  endtask

  task automatic cycle(input logic iv, input logic [W-1:0] vec, input logic ordy);
    drive(iv, vec, ordy);
    step();
  endtask

  initial begin
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b0;
    zd_exp    = 1'b0;
    exp_valid = 1'b0;
    exp_rdy   = 1'b1;
    rst_n     = 1'b0;
    #1;
    check_eq("rst_out_valid",  32'(out_valid),  32'd0);
    check_eq("rst_out_onehot", 32'(out_onehot), 32'd0);
    check_eq("rst_out_last",   32'(out_last),   32'd0);
    check_eq("rst_pend_cnt",   32'(pend_cnt),   32'd0);
    check_eq("rst_zero_drop",  32'(zero_drop),  32'd0);
    check_eq("rst_in_ready",   32'(in_ready),   32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single bit
    cycle(1'b1, 8'h40, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    check_eq("single_hot",  32'(out_onehot),         32'h40);
    check_eq("single_last", 32'(out_last),           32'd1);
    check_eq("single_cnt",  32'(pend_cnt),           32'd1);
    check_eq("single_enc",  32'(encode(out_onehot)), 32'd6);
    step();
    cycle(1'b0, 8'h00, 1'b1);

    // Multi-bit with backpressure on the second beat
    cycle(1'b1, 8'hA5, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    check_eq("multi_hot0", 32'(out_onehot), 32'h01);
    check_eq("multi_cnt0", 32'(pend_cnt),   32'd4);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h33, 1'b0);
      check_eq("bp_hot",   32'(out_onehot), 32'h04);
      check_eq("bp_cnt",   32'(pend_cnt),   32'd3);
      check_eq("bp_ready", 32'(in_ready),   32'd0);
      step();
    end
    cycle(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    check_eq("multi_hot2",  32'(out_onehot), 32'h20);
    check_eq("multi_last2", 32'(out_last),   32'd0);
    step();
    drive(1'b0, 8'h00, 1'b1);
    check_eq("multi_hot3",  32'(out_onehot), 32'h80);
    check_eq("multi_last3", 32'(out_last),   32'd1);
    step();
    cycle(1'b0, 8'h00, 1'b1);

    // Zero vector
    cycle(1'b1, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    check_eq("zero_pulse", 32'(zero_drop), 32'd1);
    check_eq("zero_valid", 32'(out_valid), 32'd0);
    check_eq("zero_ready", 32'(in_ready),  32'd1);
    step();
    drive(1'b0, 8'h00, 1'b1);
    check_eq("zero_pulse_end", 32'(zero_drop), 32'd0);
    step();

    // Back-to-back 8'h02 then 8'hFF with no gap
    cycle(1'b1, 8'h02, 1'b1);
    drive(1'b1, 8'hFF, 1'b1);
    check_eq("b2b_ready", 32'(in_ready),   32'd1);
    check_eq("b2b_hot",   32'(out_onehot), 32'h02);
    step();
    for (int i = 0; i < W; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      check_eq("b2b_seq", 32'(out_onehot), 32'(1 << i));
      step();
    end

    // Reset during the second beat of 8'hF0
    cycle(1'b1, 8'hF0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    check_eq("rmid_hot", 32'(out_onehot), 32'h20);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rmid_valid", 32'(out_valid), 32'd0);
    check_eq("rmid_cnt",   32'(pend_cnt),  32'd0);
    check_eq("rmid_ready", 32'(in_ready),  32'd1);
    bit_q.delete();
    zd_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 8'h00, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [W-1:0] v;
      case ($urandom_range(0, 7))
        0:       v = '0;
        1:       v = W'(1) << $urandom_range(0, W - 1);
        default: v = W'($urandom);
      endcase
      cycle(1'($urandom_range(0, 1)), v, ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
